btb_assoc: RTL and testbench

N-way set-associative, tagged branch target buffer for the IF stage; successor to the direct-mapped untagged BTB. Per entry: valid bit, partial tag, 32-bit target, 2-bit saturating counter, unconditional-jump flag. Combinational lookup on the fetch PC gives a hit/taken/target prediction in the same cycle. Execute-stage resolutions update entries one cycle later; misses allocate via per-set round-robin replacement.

---
 rtl/btb_assoc.sv | 121 ++++++++++++
 tb/tb_btb_assoc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative tagged branch target buffer with
// combinational fetch lookup and per-set round-robin allocation.
module btb_assoc #(
  parameter int SETW = 6,
  parameter int WAYS = 2,
  parameter int TAGW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        set_i,
  input  logic [31:0] set_pc_i,
  input  logic        set_taken_i,
  input  logic [31:0] set_target_i,
  input  logic        set_uncond_i,
  output logic        pre_hit_o,
  output logic        pre_taken_o,
  output logic [31:0] pre_target_o
);
  localparam int SETS = 1 << SETW;
  localparam int PW = WAYS > 1 ? $clog2(WAYS) : 1;

  logic            val_q [SETS][WAYS];
  logic            val_d [SETS][WAYS];
  logic [TAGW-1:0] tag_q [SETS][WAYS];
  logic [TAGW-1:0] tag_d [SETS][WAYS];
  logic [31:0]     tgt_q [SETS][WAYS];
  logic [31:0]     tgt_d [SETS][WAYS];
  logic [1:0]      cnt_q [SETS][WAYS];
  logic [1:0]      cnt_d [SETS][WAYS];
  logic            unc_q [SETS][WAYS];
  logic            unc_d [SETS][WAYS];
  logic [PW-1:0]   rr_q  [SETS];
  logic [PW-1:0]   rr_d  [SETS];

  logic [SETW-1:0] p_idx, s_idx;
  logic [TAGW-1:0] p_tag, s_tag;
  logic            p_hit, s_hit, s_inv;
  logic [PW-1:0]   p_way, s_way, vic;
  logic [1:0]      c;

  assign p_idx = pc_i[SETW+1:2];
  assign p_tag = pc_i[SETW+TAGW+1:SETW+2];
  assign s_idx = set_pc_i[SETW+1:2];
  assign s_tag = set_pc_i[SETW+TAGW+1:SETW+2];

  always_comb begin
    p_hit = 1'b0;
    p_way = '0;
    s_hit = 1'b0;
    s_way = '0;
    s_inv = 1'b0;
    vic = WAYS > 1 ? rr_q[s_idx] : '0;
    for (int w = 0; w < WAYS; w++) begin
      if (val_q[p_idx][w] && tag_q[p_idx][w] == p_tag) begin
        p_hit = 1'b1;
        p_way = PW'(w);
      end
      if (val_q[s_idx][w] && tag_q[s_idx][w] == s_tag) begin
        s_hit = 1'b1;
        s_way = PW'(w);
      end
    end
    // descending scan leaves the lowest-index invalid way as victim
    for (int w = WAYS - 1; w >= 0; w--)
      if (!val_q[s_idx][w]) begin
        s_inv = 1'b1;
        vic = PW'(w);
      end
  end

  assign pre_hit_o    = p_hit;
  assign pre_taken_o  = p_hit && (unc_q[p_idx][p_way] || cnt_q[p_idx][p_way][1]);
  assign pre_target_o = p_hit ? tgt_q[p_idx][p_way] : 32'h0;

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    unc_d = unc_q;
    rr_d  = rr_q;
    c = cnt_q[s_idx][s_way];
    if (flush_i) begin
      val_d = '{default: '0};
      rr_d  = '{default: '0};
    end else if (!stall && set_i && s_hit) begin
      cnt_d[s_idx][s_way] = set_taken_i ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
      if (set_taken_i) tgt_d[s_idx][s_way] = set_target_i;
      unc_d[s_idx][s_way] = set_uncond_i;
    end else if (!stall && set_i && set_taken_i) begin
      val_d[s_idx][vic] = 1'b1;
      tag_d[s_idx][vic] = s_tag;
      tgt_d[s_idx][vic] = set_target_i;
      cnt_d[s_idx][vic] = 2'b10;
      unc_d[s_idx][vic] = set_uncond_i;
      // pointer only moves when a live entry is displaced
      if (!s_inv && WAYS > 1) rr_d[s_idx] = rr_q[s_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '{default: '0};
      tag_q <= '{default: '0};
      tgt_q <= '{default: '0};
      cnt_q <= '{default: '0};
      unc_q <= '{default: '0};
      rr_q  <= '{default: '0};
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      unc_q <= unc_d;
      rr_q  <= rr_d;
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed stimulus pushes expected lookups into a queue;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_btb_assoc;
  logic        clk, rst, stall, flush_i, set_i, set_taken_i, set_uncond_i;
  logic [31:0] pc_i, set_pc_i, set_target_i;
  logic        pre_hit_o, pre_taken_o;
  logic [31:0] pre_target_o;
  logic        probe;
  int          checks, failures;

  typedef struct {
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    string       nm;
  } exp_t;
  exp_t q[$];

  btb_assoc #(.SETW(6), .WAYS(2), .TAGW(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_i(flush_i), .pc_i(pc_i),
    .set_i(set_i), .set_pc_i(set_pc_i), .set_taken_i(set_taken_i),
    .set_target_i(set_target_i), .set_uncond_i(set_uncond_i),
    .pre_hit_o(pre_hit_o), .pre_taken_o(pre_taken_o), .pre_target_o(pre_target_o)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (probe) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor: probe with empty expectation queue");
      end else begin
        exp_t e;
        e = q.pop_front();
        checks += 3;
        if (pre_hit_o !== e.hit) begin
          failures++;
          $display("FAIL %s hit: got %b want %b", e.nm, pre_hit_o, e.hit);
        end
        if (pre_taken_o !== e.tk) begin
          failures++;
          $display("FAIL %s taken: got %b want %b", e.nm, pre_taken_o, e.tk);
        end
        if (pre_target_o !== e.tgt) begin
          failures++;
          $display("FAIL %s target: got %h want %h", e.nm, pre_target_o, e.tgt);
        end
      end
    end
  end

  task automatic chk(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg, input string nm);
    exp_t e;
    e.hit = h;
    e.tk = t;
    e.tgt = tg;
    e.nm = nm;
    pc_i = pc;
    q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic u);
    set_i = 1'b1;
    set_pc_i = pc;
    set_taken_i = tk;
    set_target_i = tg;
    set_uncond_i = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    probe = 1'b0;
    set_i = 1'b0;
    stall = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    {stall, flush_i, set_i, set_taken_i, set_uncond_i, probe} = '0;
    pc_i = 32'h0;
    set_pc_i = 32'h0;
    set_target_i = 32'h0;
    checks = 0;
    failures = 0;
    chk(32'h00400010, 0, 0, 32'h0, "reset");
    step();
    rst = 1'b1;
    upd(32'h00400010, 1, 32'h00400100, 0);
    chk(32'h00400010, 0, 0, 32'h0, "pre_alloc");
    step();
    chk(32'h00400010, 1, 1, 32'h00400100, "alloc");
    upd(32'h00400010, 0, 32'h00000999, 0);
    step();
    chk(32'h00400010, 1, 0, 32'h00400100, "nt1_cnt01");
    upd(32'h00400010, 0, 32'h00000999, 0);
    step();
    chk(32'h00400010, 1, 0, 32'h00400100, "nt2_cnt00");
    upd(32'h00400010, 1, 32'h00400200, 0);
    step();
    chk(32'h00400010, 1, 0, 32'h00400200, "tk_cnt01");
    upd(32'h00400010, 1, 32'h00400200, 0);
    step();
    chk(32'h00400010, 1, 1, 32'h00400200, "tk_cnt10");
    upd(32'h00400020, 0, 32'h00000300, 0);
    step();
    chk(32'h00400020, 0, 0, 32'h0, "nt_miss_noalloc");
    upd(32'h00400020, 1, 32'h00000300, 0);
    stall = 1'b1;
    step();
    chk(32'h00400020, 0, 0, 32'h0, "stall_noalloc");
    upd(32'h00400010, 1, 32'h00400200, 0);
    step();
    chk(32'h00400010, 1, 1, 32'h00400200, "cnt11");
    upd(32'h00400010, 1, 32'h00400200, 0);
    step();
    chk(32'h00400010, 1, 1, 32'h00400200, "cnt11_sat");
    upd(32'h00400010, 0, 32'h00000999, 0);
    step();
    chk(32'h00400010, 1, 1, 32'h00400200, "sat_then_nt_cnt10");
    step();
    upd(32'h00401010, 1, 32'h00001111, 0);
    chk(32'h00401010, 0, 0, 32'h0, "b_pre");
    step();
    chk(32'h00401010, 1, 1, 32'h00001111, "b_way1");
    upd(32'h00402010, 1, 32'h00002222, 0);
    step();
    chk(32'h00400010, 0, 0, 32'h0, "a_evicted");
    step();
    chk(32'h00401010, 1, 1, 32'h00001111, "b_kept");
    step();
    chk(32'h00402010, 1, 1, 32'h00002222, "c_hit");
    upd(32'h00403010, 1, 32'h00003333, 0);
    step();
    chk(32'h00401010, 0, 0, 32'h0, "b_evicted");
    step();
    chk(32'h00403010, 1, 1, 32'h00003333, "d_hit");
    step();
    chk(32'h00402010, 1, 1, 32'h00002222, "c_kept");
    step();
    upd(32'h00400040, 1, 32'h00004444, 1);
    step();
    chk(32'h00400040, 1, 1, 32'h00004444, "uncond_alloc");
    upd(32'h00400040, 0, 32'h00000999, 1);
    step();
    upd(32'h00400040, 0, 32'h00000999, 1);
    step();
    upd(32'h00400040, 0, 32'h00000999, 1);
    step();
    chk(32'h00400040, 1, 1, 32'h00004444, "uncond_cnt00");
    upd(32'h00400080, 1, 32'h00005555, 0);
    flush_i = 1'b1;
    stall = 1'b1;
    step();
    chk(32'h00400040, 0, 0, 32'h0, "flush_uncond");
    step();
    chk(32'h00400080, 0, 0, 32'h0, "flush_dropped_upd");
    step();
    chk(32'h00402010, 0, 0, 32'h0, "flush_c");
    step();
    upd(32'h00400090, 1, 32'h00006666, 0);
    chk(32'h00400090, 0, 0, 32'h0, "same_cycle_nobypass");
    step();
    chk(32'h00400090, 1, 1, 32'h00006666, "next_cycle_hit");
    step();
    chk(32'h00400090, 0, 0, 32'h0, "async_reset");
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
    chk(32'h00400090, 0, 0, 32'h0, "post_reset");
    step();
    step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
